// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event pulses to HIGH_CYC-wide levels separated by GAP_CYC low cycles,
// queueing overlapping events. Define PSTRETCH_OVF_EN to add the sticky ovf flag and ovf_clr.
module pulse_stretcher #(
    parameter int HIGH_CYC = 4,
    parameter int GAP_CYC  = 2,
    parameter int PEND_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse,
`ifdef PSTRETCH_OVF_EN
    input  logic              ovf_clr,
    output logic              ovf,
`endif
    output logic              stretch,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt
);

    localparam int MAXC = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0]     HIGH_LD  = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0]     GAP_LD   = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            inc, dec, gap_end;

    // Saturating queue update; an increment paired with a decrement always fits.
    function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] p,
                                                    input logic inc_i, input logic dec_i);
        if (inc_i && !dec_i && p != PEND_MAX)
            return p + PEND_W'(1);
        if (dec_i && !inc_i)
            return p - PEND_W'(1);
        return p;
    endfunction

    always_comb begin
        gap_end = (cnt == '0) &&
                  ((state == GAP) || (state == HIGH && GAP_CYC == 0));
        state_nx = state;
        cnt_nx   = cnt;
        inc      = 1'b0;
        dec      = 1'b0;
        if (gap_end) begin
            if (pend_cnt != '0) begin
                state_nx = HIGH;
                cnt_nx   = HIGH_LD;
                dec      = 1'b1;
                inc      = pulse;
            end else if (pulse) begin
                state_nx = HIGH;
                cnt_nx   = HIGH_LD;
            end else begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pulse) begin
                        state_nx = HIGH;
                        cnt_nx   = HIGH_LD;
                    end
                end
                HIGH: begin
                    inc = pulse;
                    if (cnt == '0) begin
                        state_nx = GAP;
                        cnt_nx   = GAP_LD;
                    end else begin
                        cnt_nx = cnt - CW'(1);
                    end
                end
                GAP: begin
                    inc    = pulse;
                    cnt_nx = cnt - CW'(1);
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            stretch  <= 1'b0;
            busy     <= 1'b0;
            pend_cnt <= '0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            stretch  <= (state_nx == HIGH);
            busy     <= (state_nx != IDLE);
            pend_cnt <= pend_next(pend_cnt, inc, dec);
        end
    end

`ifdef PSTRETCH_OVF_EN
    logic drop;
    assign drop = inc && !dec && (pend_cnt == PEND_MAX);

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk) begin
        if (reset)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: a default instance and a GAP_CYC=0 instance share the inputs.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pulse = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       stretch_a, busy_a, stretch_b, busy_b;
    logic [2:0] pend_a, pend_b;
    logic       ovf_a, ovf_b;

    int checks = 0;
    int failures = 0;
    logic [2:0] pend_log [0:63];
    logic       ovf_log  [0:63];

    always #5 clk = ~clk;

    pulse_stretcher #(.HIGH_CYC(4), .GAP_CYC(2), .PEND_W(3)) dut_a (
        .clk(clk), .reset(reset), .pulse(pulse),
`ifdef PSTRETCH_OVF_EN
        .ovf_clr(ovf_clr), .ovf(ovf_a),
`endif
        .stretch(stretch_a), .busy(busy_a), .pend_cnt(pend_a)
    );

    pulse_stretcher #(.HIGH_CYC(4), .GAP_CYC(0), .PEND_W(3)) dut_b (
        .clk(clk), .reset(reset), .pulse(pulse),
`ifdef PSTRETCH_OVF_EN
        .ovf_clr(ovf_clr), .ovf(ovf_b),
`endif
        .stretch(stretch_b), .busy(busy_b), .pend_cnt(pend_b)
    );

`ifndef PSTRETCH_OVF_EN
    assign ovf_a = 1'b0;
    assign ovf_b = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] m = '0;
        for (int i = a; i < b; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] at(input int k);
        logic [63:0] m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        pulse = 1'b0;
        ovf_clr = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Drives edges 1..n from the masks; logs pend/ovf, optionally checks stretch/busy per edge.
    task automatic run(input bit sel_b, input int n, input logic [63:0] pm, input logic [63:0] rm,
                       input logic [63:0] cm, input logic [63:0] sm, input logic [63:0] bm,
                       input bit chk_sb, input string name);
        for (int e = 1; e <= n; e++) begin
            pulse   = pm[e];
            reset   = rm[e];
            ovf_clr = cm[e];
            @(posedge clk); #1;
            pend_log[e] = sel_b ? pend_b : pend_a;
            ovf_log[e]  = sel_b ? ovf_b : ovf_a;
            if (chk_sb) begin
                chk($sformatf("%s stretch@%0d", name, e), {31'd0, sel_b ? stretch_b : stretch_a}, {31'd0, sm[e]});
                chk($sformatf("%s busy@%0d", name, e), {31'd0, sel_b ? busy_b : busy_a}, {31'd0, bm[e]});
            end
        end
        pulse = 1'b0;
        reset = 1'b0;
        ovf_clr = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset stretch", {31'd0, stretch_a}, 32'd0);
        chk("reset busy", {31'd0, busy_a}, 32'd0);
        chk("reset pend", {29'd0, pend_a}, 32'd0);
        chk("reset stretch b", {31'd0, stretch_b}, 32'd0);

        // Single pulse
        run(1'b0, 20, at(10), '0, '0, rng(10, 14), rng(10, 16), 1'b1, "t1");
        chk("t1 pend@12", {29'd0, pend_log[12]}, 32'd0);
        chk("t1 pend@16", {29'd0, pend_log[16]}, 32'd0);

        // Queued pulses replayed back-to-back
        do_reset();
        run(1'b0, 30, at(10) | at(12) | at(13), '0, '0,
            rng(10, 14) | rng(16, 20) | rng(22, 26), rng(10, 28), 1'b1, "t2");
        chk("t2 pend@12", {29'd0, pend_log[12]}, 32'd1);
        chk("t2 pend@13", {29'd0, pend_log[13]}, 32'd2);
        chk("t2 pend@16", {29'd0, pend_log[16]}, 32'd1);
        chk("t2 pend@22", {29'd0, pend_log[22]}, 32'd0);

        // Held pulse saturates the queue
        do_reset();
        run(1'b0, 24, rng(10, 22), '0, at(22), '0, '0, 1'b0, "t3");
        chk("t3 pend@15", {29'd0, pend_log[15]}, 32'd5);
        chk("t3 pend@16", {29'd0, pend_log[16]}, 32'd5);
        chk("t3 pend@18", {29'd0, pend_log[18]}, 32'd7);
        chk("t3 pend@21", {29'd0, pend_log[21]}, 32'd7);
        chk("t3 pend@22", {29'd0, pend_log[22]}, 32'd6);
`ifdef PSTRETCH_OVF_EN
        chk("t3 ovf@18", {31'd0, ovf_log[18]}, 32'd0);
        chk("t3 ovf@19", {31'd0, ovf_log[19]}, 32'd1);
        chk("t3 ovf@21", {31'd0, ovf_log[21]}, 32'd1);
        chk("t3 ovf@22", {31'd0, ovf_log[22]}, 32'd0);
`endif

        // Pulse exactly at gap end, empty queue
        do_reset();
        run(1'b0, 24, at(10) | at(16), '0, '0, rng(10, 14) | rng(16, 20), rng(10, 22), 1'b1, "t4a");
        chk("t4a pend@16", {29'd0, pend_log[16]}, 32'd0);

        // Pulse at gap end with two queued
        do_reset();
        run(1'b0, 36, at(10) | at(11) | at(12) | at(16), '0, '0,
            rng(10, 14) | rng(16, 20) | rng(22, 26) | rng(28, 32), rng(10, 34), 1'b1, "t4b");
        chk("t4b pend@15", {29'd0, pend_log[15]}, 32'd2);
        chk("t4b pend@16", {29'd0, pend_log[16]}, 32'd2);
        chk("t4b pend@22", {29'd0, pend_log[22]}, 32'd1);
        chk("t4b pend@28", {29'd0, pend_log[28]}, 32'd0);

        // Reset mid-stretch with pulse on the reset edge
        do_reset();
        run(1'b0, 16, rng(8, 13), at(12), '0, rng(8, 12), rng(8, 12), 1'b1, "t5");
        chk("t5 pend@11", {29'd0, pend_log[11]}, 32'd3);
        chk("t5 pend@12", {29'd0, pend_log[12]}, 32'd0);
        chk("t5 pend@13", {29'd0, pend_log[13]}, 32'd0);

        // Zero gap merges stretches
        do_reset();
        run(1'b1, 22, at(10) | at(11), '0, '0, rng(10, 18), rng(10, 18), 1'b1, "t6");
        chk("t6 pend@11", {29'd0, pend_log[11]}, 32'd1);
        chk("t6 pend@14", {29'd0, pend_log[14]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
